// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, LED byte layout and the LED command sequencer state type.
// Used by both the keyboard state block and the LED command sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESP_RESEND  = 8'hFE;

  localparam int unsigned LED_SCROLL_BIT = 0;
  localparam int unsigned LED_NUM_BIT    = 1;
  localparam int unsigned LED_CAPS_BIT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_CMD_ACK,
    ST_SEND_DATA,
    ST_WAIT_DATA_ACK
  } ps2_led_state_t;

  function automatic logic [7:0] ps2_led_byte(input logic caps, input logic num,
                                              input logic scroll);
    logic [7:0] b;
    b                 = '0;
    b[LED_SCROLL_BIT] = scroll;
    b[LED_NUM_BIT]    = num;
    b[LED_CAPS_BIT]   = caps;
    return b;
  endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// Acknowledge timeout counter: cleared when a byte is accepted, counts while waiting,
// saturates instead of wrapping, and flags expiry at TIMEOUT_CYCLES-1.
module ps2_ack_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_350_000
) (
  input  logic clk,
  input  logic reset_low,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/ps2_led_command.sv
// Host-to-keyboard Set/Reset LEDs sequencer: sends 0xED then the LED byte,
// retrying on resend/timeout up to MAX_RETRIES before aborting with an error pulse.
module ps2_led_command
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_350_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       set_status,
  input  logic       set_status_caps_lock,
  input  logic       set_status_num_lock,
  input  logic       set_status_scroll_lock,
  input  logic       acknowledge,
  input  logic       resend,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       error
);

  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  ps2_led_state_t state, state_nxt;

  logic          pending;
  logic [7:0]    next_led;
  logic [7:0]    led_byte;
  logic [RW-1:0] retry;
  logic          error_q;

  logic xfer;
  logic in_wait;
  logic expired;
  logic fail_evt;
  logic retries_done;
  logic start_seq;

  assign xfer         = tx_valid & tx_ready;
  assign in_wait      = (state == ST_WAIT_CMD_ACK) || (state == ST_WAIT_DATA_ACK);
  // acknowledge outranks a simultaneous resend or expiry
  assign fail_evt     = in_wait & ~acknowledge & (resend | expired);
  assign retries_done = (retry == RETRY_LIMIT);
  assign start_seq    = (state == ST_IDLE) & pending;

  ps2_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk      (clk),
    .reset_low(reset_low),
    .clear    (xfer),
    .count_en (in_wait),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (pending) state_nxt = ST_SEND_CMD;
      end
      ST_SEND_CMD: begin
        if (tx_ready) state_nxt = ST_WAIT_CMD_ACK;
      end
      ST_WAIT_CMD_ACK: begin
        if (acknowledge)   state_nxt = ST_SEND_DATA;
        else if (fail_evt) state_nxt = retries_done ? ST_IDLE : ST_SEND_CMD;
      end
      ST_SEND_DATA: begin
        if (tx_ready) state_nxt = ST_WAIT_DATA_ACK;
      end
      ST_WAIT_DATA_ACK: begin
        if (acknowledge)   state_nxt = ST_IDLE;
        else if (fail_evt) state_nxt = retries_done ? ST_IDLE : ST_SEND_DATA;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = '0;
    busy     = (state != ST_IDLE);
    unique case (state)
      ST_SEND_CMD: begin
        tx_valid = 1'b1;
        tx_byte  = PS2_CMD_SET_LEDS;
      end
      ST_SEND_DATA: begin
        tx_valid = 1'b1;
        tx_byte  = led_byte;
      end
      default: ;
    endcase
  end

  // A request landing in the same cycle IDLE consumes the previous one stays pending.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      pending  <= 1'b0;
      next_led <= '0;
      led_byte <= '0;
      retry    <= '0;
      error_q  <= 1'b0;
    end else begin
      if (set_status) begin
        pending  <= 1'b1;
        next_led <= ps2_led_byte(set_status_caps_lock, set_status_num_lock,
                                 set_status_scroll_lock);
      end else if (start_seq) begin
        pending <= 1'b0;
      end

      if (start_seq) led_byte <= next_led;

      if (start_seq) begin
        retry <= '0;
      end else if ((state == ST_WAIT_CMD_ACK) && acknowledge) begin
        retry <= '0;
      end else if (fail_evt && !retries_done) begin
        retry <= retry + 1'b1;
      end

      error_q <= fail_evt & retries_done;
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_ps2_led_command.sv
// Randomized bench for ps2_led_command: a scripted keyboard responder plus a
// transaction-level model of the expected byte stream, timing and error outcome.
module tb_ps2_led_command;

  localparam int TMO  = 16;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       reset_low;
  logic       set_status, caps, num, scroll;
  logic       acknowledge, resend;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_byte;
  logic       busy, error;

  ps2_led_command #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk                   (clk),
    .reset_low             (reset_low),
    .set_status            (set_status),
    .set_status_caps_lock  (caps),
    .set_status_num_lock   (num),
    .set_status_scroll_lock(scroll),
    .acknowledge           (acknowledge),
    .resend                (resend),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .tx_byte               (tx_byte),
    .busy                  (busy),
    .error                 (error)
  );

  always #5 clk = ~clk;

  // kind: 0 ack, 1 resend, 2 silent (timeout), 3 ack+resend together
  // ends: 0 sequence continues, 1 sequence completes, 2 sequence aborts
  typedef struct {
    int       kind;
    int       d;
    int       k;
    bit       inj;
    logic [2:0] inj_led;
    int       ends;
  } plan_t;

  plan_t      plan_q[$];
  logic [7:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int errs_exp, errs_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void pick(input int mode, input int ph, input int a, output plan_t e);
    int r;
    e.inj = 1'b0; e.inj_led = '0; e.ends = 0;
    case (mode)
      1: begin e.kind = 0; e.d = 3; e.k = 0; end
      2: begin e.kind = (a == 0) ? 1 : 0; e.d = 2; e.k = 0; end
      3: begin e.kind = 2; e.d = 0; e.k = 0; end
      4: begin
        e.kind = (ph == 0 && a == 0) ? 1 : 0;
        e.d    = 3;
        e.k    = (ph == 0 && a == 0) ? 10 : 0;
      end
      default: begin
        r = int'($urandom_range(0, 99));
        e.kind = (r < 50) ? 0 : (r < 70) ? 1 : (r < 85) ? 2 : 3;
        e.d    = int'($urandom_range(1, TMO));
        r      = int'($urandom_range(0, 9));
        e.k    = (r < 7) ? 0 : (r < 9) ? int'($urandom_range(1, 3)) : 10;
      end
    endcase
  endfunction

  // Expected bytes of one Set LEDs sequence: each byte is retried until acked,
  // at most MAXR retransmissions, after which the sequence is abandoned.
  function automatic void gen_seq(input logic [2:0] led, input int mode);
    plan_t e;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a <= MAXR; a++) begin
        pick(mode, ph, a, e);
        exp_q.push_back(ph == 0 ? 8'hED : {5'b0, led});
        if (e.kind == 0 || e.kind == 3) begin
          e.ends = (ph == 1) ? 1 : 0;
          plan_q.push_back(e);
          break;
        end
        if (a == MAXR) begin
          e.ends = 2;
          plan_q.push_back(e);
          errs_exp++;
          return;
        end
        plan_q.push_back(e);
      end
    end
  endfunction

  function automatic void add_inj(input int idx, input logic [2:0] v);
    plan_t t;
    t = plan_q[idx];
    t.inj = 1'b1;
    t.inj_led = v;
    plan_q[idx] = t;
  endfunction

  task automatic run_scenario(input logic [2:0] led, input int mode, input int inj_mode);
    int resp_at, resp_kind, stall_lo, stall_hi, inj_at, end_at, quiet_until, next_xfer;
    int rc, earliest, last, n, i1, i2;
    bit stall_in_seq, end_err, stalled, done;
    logic [2:0] inj_led, v1, v2, lastv;
    plan_t p;

    plan_q.delete(); exp_q.delete();
    errs_exp = 0; errs_seen = 0;
    gen_seq(led, mode);
    last = plan_q.size() - 1;
    if (inj_mode == 1) begin
      add_inj(0, 3'b100);
      add_inj(last, 3'b001);
      gen_seq(3'b001, mode);
    end else if (inj_mode == 2) begin
      n = int'($urandom_range(0, 2));
      if (n > 0) begin
        i1 = int'($urandom_range(0, last));
        i2 = int'($urandom_range(0, last));
        v1 = 3'($urandom); v2 = 3'($urandom);
        if (n == 1) begin
          add_inj(i1, v1); lastv = v1;
        end else begin
          if (i1 != i2) add_inj((i1 < i2) ? i1 : i2, v1);
          add_inj((i1 < i2) ? i2 : i1, v2);
          lastv = v2;
        end
        gen_seq(lastv, 0);
      end
    end

    resp_at = -1; resp_kind = 0; stall_lo = 1; stall_hi = 0; stall_in_seq = 0;
    end_at = -1; end_err = 0; quiet_until = -1; done = 0;
    inj_at = cyc + 1; inj_led = led;
    next_xfer = inj_at + 2;

    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      cyc++;
      set_status = (cyc == inj_at);
      {caps, num, scroll} = inj_led;
      acknowledge = (cyc == resp_at) && (resp_kind == 0 || resp_kind == 3);
      resend      = (cyc == resp_at) && (resp_kind == 1 || resp_kind == 3);
      stalled     = (cyc >= stall_lo) && (cyc <= stall_hi);
      tx_ready    = !stalled;
      if (stalled && $urandom_range(0, 3) == 0) begin
        acknowledge = 1'($urandom_range(0, 1));
        resend      = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      if (error) errs_seen++;
      if (cyc == end_at) begin
        chk("busy_after_end", busy, 0);
        chk("error_pulse", error, end_err);
      end
      if (stalled && stall_in_seq) begin
        chk("stall_hold_valid", tx_valid, 1);
        if (exp_q.size() > 0) chk("stall_hold_byte", tx_byte, exp_q[0]);
      end
      if (tx_valid && tx_ready) begin
        if (plan_q.size() == 0) begin
          chk("extra_xfer", 1, 0);
        end else begin
          chk("xfer_cycle", cyc, next_xfer);
          chk("xfer_byte", tx_byte, exp_q.pop_front());
          p  = plan_q.pop_front();
          rc = cyc + ((p.kind == 2) ? TMO : p.d);
          resp_at   = (p.kind == 2) ? -1 : rc;
          resp_kind = p.kind;
          stall_lo  = rc + 1;
          stall_hi  = rc + p.k;
          stall_in_seq = (p.ends == 0);
          if (p.inj) begin
            inj_at  = rc;
            inj_led = p.inj_led;
          end
          earliest = rc + 1;
          if (p.ends != 0) begin
            end_at   = rc + 1;
            end_err  = (p.ends == 2);
            earliest = rc + 2;
          end
          next_xfer = (earliest > rc + p.k + 1) ? earliest : rc + p.k + 1;
          if (plan_q.size() == 0)
            quiet_until = ((rc + p.k > rc + 1) ? rc + p.k : rc + 1) + 4;
        end
      end
      if (plan_q.size() == 0 && cyc == quiet_until) begin
        chk("quiet_tx_valid", tx_valid, 0);
        chk("quiet_busy", busy, 0);
        done = 1;
      end
    end

    if (!done) chk("scenario_budget", 0, 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("error_count", errs_seen, errs_exp);
    set_status = 0; acknowledge = 0; resend = 0; tx_ready = 1;
  endtask

  task automatic reset_mid();
    bit seen;
    int cnt;
    @(posedge clk); #1; cyc++;
    set_status = 1; {caps, num, scroll} = 3'b011;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1; cyc++;
      set_status = 0;
      @(negedge clk);
      if (tx_valid && tx_ready && tx_byte == 8'hED) seen = 1;
    end
    chk("rst_cmd_seen", seen, 1);
    @(posedge clk); #1; cyc++;
    acknowledge = 1;
    @(posedge clk); #1; cyc++;
    acknowledge = 0;
    @(negedge clk);
    chk("rst_data_valid", tx_valid, 1);
    chk("rst_data_byte", tx_byte, 8'h03);
    repeat (3) begin @(posedge clk); #1; cyc++; end
    @(negedge clk); #2;
    chk("rst_busy_before", busy, 1);
    reset_low = 0;
    #1;
    chk("rst_async_outputs", {tx_valid, busy, error, tx_byte}, 0);
    repeat (2) @(posedge clk);
    #1; reset_low = 1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_valid) cnt++;
    end
    chk("rst_no_reoffer", cnt, 0);
    chk("rst_idle_busy", busy, 0);
  endtask

  initial begin
    reset_low = 0; set_status = 0; caps = 0; num = 0; scroll = 0;
    acknowledge = 0; resend = 0; tx_ready = 1;
    #1;
    chk("reset_outputs", {tx_valid, busy, error, tx_byte}, 0);
    repeat (3) @(posedge clk);
    #1; reset_low = 1;
    @(negedge clk);
    chk("post_reset_idle", {tx_valid, busy}, 0);

    run_scenario(3'b101, 1, 0);   // 0xED, 0x05
    run_scenario(3'b010, 2, 0);   // 0xED, 0xED, 0x02, 0x02
    run_scenario(3'b111, 3, 0);   // three 0xED then abort
    run_scenario(3'b110, 4, 0);   // 10-cycle stall on a retried 0xED
    run_scenario(3'b111, 1, 1);   // 0x04, 0x01 mid-sequence, last lands with final ack
    for (int s = 0; s < 25; s++) run_scenario(3'($urandom), 0, 2);
    reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
